// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered add/sub ALU between two ports.
module alu_arbiter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_0,
  output logic                 req_ready_0,
  input  logic [DATA_BITS-1:0] req_a_0,
  input  logic [DATA_BITS-1:0] req_b_0,
  input  logic                 req_sub_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_1,
  input  logic [DATA_BITS-1:0] req_a_1,
  input  logic [DATA_BITS-1:0] req_b_1,
  input  logic                 req_sub_1,
  output logic                 rsp_valid_0,
  input  logic                 rsp_ready_0,
  output logic [DATA_BITS-1:0] rsp_result_0,
  output logic                 rsp_cout_0,
  output logic                 rsp_zero_0,
  output logic                 rsp_valid_1,
  input  logic                 rsp_ready_1,
  output logic [DATA_BITS-1:0] rsp_result_1,
  output logic                 rsp_cout_1,
  output logic                 rsp_zero_1,
  output logic [DATA_BITS-1:0] alu_a,
  output logic [DATA_BITS-1:0] alu_b,
  output logic                 alu_cin,
  input  logic [DATA_BITS-1:0] alu_result,
  input  logic                 alu_cout,
  input  logic                 alu_zero
);
  logic inflight_valid, inflight_id, last_grant;
  logic elig_0, elig_1, grant_0, grant_1;
  always_comb begin
    elig_0 = !reset && req_valid_0 && !(inflight_valid && !inflight_id) && (!rsp_valid_0 || rsp_ready_0);
    elig_1 = !reset && req_valid_1 && !(inflight_valid && inflight_id) && (!rsp_valid_1 || rsp_ready_1);
    // last_grant = 1 means port 1 won last, so port 0 takes the tie
    grant_0 = elig_0 && (!elig_1 || last_grant);
    grant_1 = elig_1 && (!elig_0 || !last_grant);
    req_ready_0 = grant_0;
    req_ready_1 = grant_1;
    alu_a = grant_0 ? req_a_0 : grant_1 ? req_a_1 : '0;
    alu_b = grant_0 ? req_b_0 : grant_1 ? req_b_1 : '0;
    alu_cin = grant_0 ? req_sub_0 : (grant_1 && req_sub_1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_valid <= 1'b0;
      inflight_id <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid_0 <= 1'b0;
      rsp_result_0 <= '0;
      rsp_cout_0 <= 1'b0;
      rsp_zero_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_result_1 <= '0;
      rsp_cout_1 <= 1'b0;
      rsp_zero_1 <= 1'b0;
    end else begin
      inflight_valid <= grant_0 || grant_1;
      if (grant_0 || grant_1) begin
        inflight_id <= grant_1;
        last_grant <= grant_1;
      end
      // capture beats consume when both land on the same edge
      if (inflight_valid && !inflight_id) begin
        rsp_valid_0 <= 1'b1;
        rsp_result_0 <= alu_result;
        rsp_cout_0 <= alu_cout;
        rsp_zero_0 <= alu_zero;
      end else if (rsp_ready_0) rsp_valid_0 <= 1'b0;
      if (inflight_valid && inflight_id) begin
        rsp_valid_1 <= 1'b1;
        rsp_result_1 <= alu_result;
        rsp_cout_1 <= alu_cout;
        rsp_zero_1 <= alu_zero;
      end else if (rsp_ready_1) rsp_valid_1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a registered add/sub ALU model.
module tb_alu_arbiter;
  logic clk = 1'b0, reset;
  logic req_valid_0, req_ready_0, req_sub_0, req_valid_1, req_ready_1, req_sub_1;
  logic [7:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic rsp_valid_0, rsp_ready_0, rsp_cout_0, rsp_zero_0;
  logic rsp_valid_1, rsp_ready_1, rsp_cout_1, rsp_zero_1;
  logic [7:0] rsp_result_0, rsp_result_1, alu_a, alu_b, alu_result;
  logic alu_cin, alu_cout, alu_zero;
  logic [8:0] sum;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sub_0(req_sub_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sub_1(req_sub_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_result_0(rsp_result_0), .rsp_cout_0(rsp_cout_0), .rsp_zero_0(rsp_zero_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_result_1(rsp_result_1), .rsp_cout_1(rsp_cout_1), .rsp_zero_1(rsp_zero_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );
  // shared ALU stand-in: a + (cin ? ~b : b) + cin, registered
  assign sum = {1'b0, alu_a} + {1'b0, alu_cin ? ~alu_b : alu_b} + {8'd0, alu_cin};
  always_ff @(posedge clk) begin
    alu_result <= sum[7:0];
    alu_cout <= sum[8];
    alu_zero <= sum[7:0] == 8'd0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic single_op(input bit p, input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [7:0] r, input logic c, input logic z);
    if (p) begin
      req_valid_1 = 1; req_a_1 = a; req_b_1 = b; req_sub_1 = s;
    end else begin
      req_valid_0 = 1; req_a_0 = a; req_b_0 = b; req_sub_0 = s;
    end
    #1;
    check("grant", p ? req_ready_1 : req_ready_0, 1);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_cin", alu_cin, s);
    tick;
    req_valid_0 = 0; req_valid_1 = 0;
    #1;
    check("rsp_early", p ? rsp_valid_1 : rsp_valid_0, 0);
    tick;
    check("rsp_valid", p ? rsp_valid_1 : rsp_valid_0, 1);
    check("rsp_result", p ? rsp_result_1 : rsp_result_0, r);
    check("rsp_cout", p ? rsp_cout_1 : rsp_cout_0, c);
    check("rsp_zero", p ? rsp_zero_1 : rsp_zero_0, z);
    tick;
  endtask
  initial begin
    reset = 1; rsp_ready_0 = 1; rsp_ready_1 = 1;
    req_valid_0 = 0; req_a_0 = 0; req_b_0 = 0; req_sub_0 = 0;
    req_valid_1 = 0; req_a_1 = 0; req_b_1 = 0; req_sub_1 = 0;
    tick; tick;
    req_valid_0 = 1;
    #1;
    check("ready_in_reset", req_ready_0, 0);
    check("rst_valid_0", rsp_valid_0, 0);
    check("rst_result_0", rsp_result_0, 0);
    check("rst_valid_1", rsp_valid_1, 0);
    reset = 0;
    single_op(0, 8'h05, 8'h03, 0, 8'h08, 0, 0);
    single_op(1, 8'hFF, 8'h01, 0, 8'h00, 1, 1);
    single_op(1, 8'h05, 8'h05, 1, 8'h00, 1, 1);
    single_op(1, 8'h03, 8'h05, 1, 8'hFE, 0, 0);
    // both ports valid from the first cycle after reset
    reset = 1;
    tick;
    reset = 0;
    req_valid_0 = 1; req_a_0 = 8'd10; req_b_0 = 8'd1; req_sub_0 = 0;
    req_valid_1 = 1; req_a_1 = 8'd20; req_b_1 = 8'd4; req_sub_1 = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("alt_ready_0", req_ready_0, k % 2 == 0);
      check("alt_ready_1", req_ready_1, k % 2 == 1);
      check("alt_alu_a", alu_a, k % 2 == 0 ? 8'd10 : 8'd20);
      check("alt_rsp_valid_0", rsp_valid_0, k >= 2 && k % 2 == 0);
      check("alt_rsp_valid_1", rsp_valid_1, k >= 3 && k % 2 == 1);
      if (k >= 2) check("alt_result", k % 2 == 0 ? rsp_result_0 : rsp_result_1, k % 2 == 0 ? 8'd11 : 8'd16);
      tick;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    tick; tick; tick;
    // port 0 response backpressured while port 1 keeps running
    rsp_ready_0 = 0;
    req_valid_0 = 1; req_a_0 = 8'h05; req_b_0 = 8'h03; req_sub_0 = 0;
    #1;
    check("bp_grant", req_ready_0, 1);
    tick;
    req_valid_0 = 0;
    tick;
    req_valid_0 = 1; req_a_0 = 8'h01; req_b_0 = 8'h01;
    req_valid_1 = 1; req_a_1 = 8'h07; req_b_1 = 8'h02; req_sub_1 = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("bp_ready_0", req_ready_0, 0);
      check("bp_hold_valid", rsp_valid_0, 1);
      check("bp_hold_result", rsp_result_0, 8'h08);
      check("bp_ready_1", req_ready_1, j % 2 == 0);
      if (j == 2) begin
        check("bp_rsp_valid_1", rsp_valid_1, 1);
        check("bp_rsp_result_1", rsp_result_1, 8'h05);
        check("bp_rsp_cout_1", rsp_cout_1, 1);
      end
      tick;
    end
    req_valid_1 = 0; rsp_ready_0 = 1;
    #1;
    check("bp_regrant", req_ready_0, 1);
    check("bp_regrant_a", alu_a, 8'h01);
    tick;
    req_valid_0 = 0;
    #1;
    check("bp_consumed", rsp_valid_0, 0);
    tick;
    check("bp_new_valid", rsp_valid_0, 1);
    check("bp_new_result", rsp_result_0, 8'h02);
    tick; tick;
    // reset in the cycle after a port 0 grant drops that op
    req_valid_0 = 1; req_a_0 = 8'h05; req_b_0 = 8'h03; req_sub_0 = 0;
    #1;
    check("mid_grant", req_ready_0, 1);
    tick;
    req_valid_0 = 0; req_valid_1 = 1; reset = 1;
    #1;
    check("mid_ready_1", req_ready_1, 0);
    tick;
    reset = 0; req_valid_1 = 0;
    #1;
    check("post_valid_0", rsp_valid_0, 0);
    check("post_result_0", rsp_result_0, 0);
    check("post_cout_0", rsp_cout_0, 0);
    check("post_zero_0", rsp_zero_0, 0);
    check("post_valid_1", rsp_valid_1, 0);
    check("post_result_1", rsp_result_1, 0);
    check("post_cout_1", rsp_cout_1, 0);
    check("post_zero_1", rsp_zero_1, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("dropped_op", rsp_valid_0, 0);
    end
    req_valid_0 = 1; req_valid_1 = 1;
    #1;
    check("tie_0", req_ready_0, 1);
    check("tie_1", req_ready_1, 0);
    tick;
    req_valid_0 = 0; req_valid_1 = 0;
    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
